// File: rtl/icache_refill_if.sv
// Miss-request, data-array refill, fetch response and AXI4 AR/R channels of the icache refill handler.
// Build macro ICACHE_REFILL_ERR_EN adds the resp_err response flag.
interface icache_refill_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 64
);
  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  miss_cache;
  logic                  miss_lru;

  logic                  refresh;
  logic                  refill_way;
  logic [5:0]            refill_index;
  logic [LINE_WIDTH-1:0] cacheline_new;

  logic                  resp_valid;
  logic [63:0]           resp_rdata;
`ifdef ICACHE_REFILL_ERR_EN
  logic                  resp_err;
`endif

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [3:0]            arid;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  // The refill handler: slave on the miss side, master on AXI.
  modport master (
    input  miss_valid, miss_addr, miss_cache, miss_lru,
    input  arready, rvalid, rdata, rresp, rlast,
`ifdef ICACHE_REFILL_ERR_EN
    output resp_err,
`endif
    output miss_ready, refresh, refill_way, refill_index, cacheline_new,
    output resp_valid, resp_rdata,
    output arvalid, araddr, arlen, arsize, arburst, arid, rready
  );

  // The surrounding tag logic, data array and AXI crossbar.
  modport slave (
    output miss_valid, miss_addr, miss_cache, miss_lru,
    output arready, rvalid, rdata, rresp, rlast,
`ifdef ICACHE_REFILL_ERR_EN
    input  resp_err,
`endif
    input  miss_ready, refresh, refill_way, refill_index, cacheline_new,
    input  resp_valid, resp_rdata,
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready
  );
endinterface

// File: rtl/icache_refill.sv
// AXI4 read-master miss handler for the instruction cache: fetches a line (or one uncached word),
// strobes the data-array refill port and returns the missed word. Optional macro: ICACHE_REFILL_ERR_EN.
module icache_refill #(
  parameter int         ADDR_WIDTH = 64,
  parameter int         DATA_WIDTH = 64,
  parameter int         LINE_WIDTH = 64,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.master bus
);

  localparam int BEATS    = LINE_WIDTH / DATA_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int WORDS    = LINE_WIDTH / 64;
  localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(BEATS - 1);
  localparam logic [7:0]            ARLEN_LINE = 8'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  =
    ~((ADDR_WIDTH'(1'b1) << OFF_BITS) - ADDR_WIDTH'(1'b1));
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(3'd7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_r;
  logic                  cache_r;
  logic                  lru_r;
  logic [5:0]            idx_r;
  logic [WIDX_W-1:0]     word_off_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [LINE_WIDTH-1:0] line_buf_r;

  logic                  miss_ready_r;
  logic                  arvalid_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [7:0]            arlen_r;
  logic [2:0]            arsize_r;
  logic [1:0]            arburst_r;
  logic [3:0]            arid_r;
  logic                  rready_r;
  logic                  refresh_r;
  logic                  refill_way_r;
  logic [5:0]            refill_index_r;
  logic [LINE_WIDTH-1:0] cacheline_new_r;
  logic                  resp_valid_r;
  logic [63:0]           resp_rdata_r;

  logic                  beat_s;
  logic [ADDR_WIDTH-1:0] masked_addr_s;
  logic [LINE_WIDTH-1:0] buf_next_s;
  logic [63:0]           resp_word_s;
  logic                  refresh_next_s;

`ifdef ICACHE_REFILL_ERR_EN
  logic err_r;
  logic resp_err_r;
  logic err_next_s;

  // Sticky bus-error flag including the beat being accepted this cycle.
  always_comb begin
    err_next_s = err_r;
    if (beat_s && (bus.rresp != 2'b00)) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_r;
    end
  end

  assign refresh_next_s = cache_r & ~err_next_s;
  assign bus.resp_err   = resp_err_r;
`else
  assign refresh_next_s = cache_r;
`endif

  // Request alignment and next line-buffer image; the final beat lands in the buffer and the
  // registered DONE outputs on the same edge, so DONE never sees a combinational R-channel path.
  always_comb begin
    beat_s        = (state_r == R) && bus.rvalid;
    masked_addr_s = bus.miss_cache ? (bus.miss_addr & LINE_MASK) : (bus.miss_addr & WORD_MASK);
    buf_next_s    = line_buf_r;
    if (beat_s) begin
      buf_next_s[int'(cnt_r)*DATA_WIDTH +: DATA_WIDTH] = bus.rdata;
    end else begin
      buf_next_s = line_buf_r;
    end
    resp_word_s = buf_next_s[int'(word_off_r)*64 +: 64];
  end

  // Refill FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      cache_r         <= 1'b0;
      lru_r           <= 1'b0;
      idx_r           <= 6'd0;
      word_off_r      <= '0;
      cnt_r           <= '0;
      line_buf_r      <= '0;
      miss_ready_r    <= 1'b1;
      arvalid_r       <= 1'b0;
      araddr_r        <= '0;
      arlen_r         <= 8'd0;
      arsize_r        <= 3'd0;
      arburst_r       <= 2'd0;
      arid_r          <= 4'd0;
      rready_r        <= 1'b0;
      refresh_r       <= 1'b0;
      refill_way_r    <= 1'b0;
      refill_index_r  <= 6'd0;
      cacheline_new_r <= '0;
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 64'd0;
`ifdef ICACHE_REFILL_ERR_EN
      err_r           <= 1'b0;
      resp_err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.miss_valid) begin
            state_r      <= AR;
            miss_ready_r <= 1'b0;
            cache_r      <= bus.miss_cache;
            lru_r        <= bus.miss_lru;
            idx_r        <= masked_addr_s[8:3];
            // Offset of the missed word within the line; cached araddr loses it.
            word_off_r   <= ((WORDS > 1) && bus.miss_cache) ? WIDX_W'(bus.miss_addr >> 3'd3) : '0;
            cnt_r        <= '0;
            line_buf_r   <= '0;
            arvalid_r    <= 1'b1;
            araddr_r     <= masked_addr_s;
            arlen_r      <= bus.miss_cache ? ARLEN_LINE : 8'd0;
            arsize_r     <= 3'b011;
            arburst_r    <= 2'b01;
            arid_r       <= AXI_ID;
`ifdef ICACHE_REFILL_ERR_EN
            err_r        <= 1'b0;
`endif
          end
        end
        AR: begin
          if (bus.arready) begin
            state_r   <= R;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        R: begin
          if (beat_s) begin
            line_buf_r <= buf_next_s;
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_W'(1'b1);
            end
`ifdef ICACHE_REFILL_ERR_EN
            err_r <= err_next_s;
`endif
            if (bus.rlast) begin
              state_r         <= DONE;
              rready_r        <= 1'b0;
              resp_valid_r    <= 1'b1;
              resp_rdata_r    <= resp_word_s;
              refresh_r       <= refresh_next_s;
              refill_way_r    <= lru_r;
              refill_index_r  <= idx_r;
              cacheline_new_r <= cache_r ? buf_next_s : '0;
`ifdef ICACHE_REFILL_ERR_EN
              resp_err_r      <= err_next_s;
`endif
            end
          end
        end
        DONE: begin
          state_r         <= IDLE;
          miss_ready_r    <= 1'b1;
          resp_valid_r    <= 1'b0;
          resp_rdata_r    <= 64'd0;
          refresh_r       <= 1'b0;
          refill_way_r    <= 1'b0;
          refill_index_r  <= 6'd0;
          cacheline_new_r <= '0;
`ifdef ICACHE_REFILL_ERR_EN
          err_r           <= 1'b0;
          resp_err_r      <= 1'b0;
`endif
        end
        default: begin
          state_r      <= IDLE;
          miss_ready_r <= 1'b1;
          arvalid_r    <= 1'b0;
          rready_r     <= 1'b0;
          refresh_r    <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miss_ready    = miss_ready_r;
  assign bus.arvalid       = arvalid_r;
  assign bus.araddr        = araddr_r;
  assign bus.arlen         = arlen_r;
  assign bus.arsize        = arsize_r;
  assign bus.arburst       = arburst_r;
  assign bus.arid          = arid_r;
  assign bus.rready        = rready_r;
  assign bus.refresh       = refresh_r;
  assign bus.refill_way    = refill_way_r;
  assign bus.refill_index  = refill_index_r;
  assign bus.cacheline_new = cacheline_new_r;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_rdata    = resp_rdata_r;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a single-beat-line instance (a) and a four-beat-line instance (b).
module tb_icache_refill;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  icache_refill_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(64))  bus_a ();
  icache_refill_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(256)) bus_b ();

  icache_refill #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(64), .AXI_ID(4'd0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  icache_refill #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(256), .AXI_ID(4'd0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_a.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready_a got=%0h exp=1", bus_a.miss_ready); end
    checks++; if (bus_a.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid_a got=%0h exp=0", bus_a.arvalid); end
    checks++; if (bus_a.rready !== 1'b0) begin errors++; $display("FAIL rst_rready_a got=%0h exp=0", bus_a.rready); end
    checks++; if (bus_a.refresh !== 1'b0) begin errors++; $display("FAIL rst_refresh_a got=%0h exp=0", bus_a.refresh); end
    checks++; if (bus_a.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid_a got=%0h exp=0", bus_a.resp_valid); end
    checks++; if (bus_a.araddr !== 64'd0) begin errors++; $display("FAIL rst_araddr_a got=%h exp=0", bus_a.araddr); end
    checks++; if (bus_b.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready_b got=%0h exp=1", bus_b.miss_ready); end
    checks++; if (bus_b.cacheline_new !== 256'd0) begin errors++; $display("FAIL rst_line_b got=%h exp=0", bus_b.cacheline_new); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cached_single();
    logic [63:0] d;
    d = 64'hDEAD_BEEF_0000_1111;
    bus_a.miss_valid = 1'b1; bus_a.miss_addr = 64'h0000_0000_8000_0128;
    bus_a.miss_cache = 1'b1; bus_a.miss_lru = 1'b1;
    bus_a.arready = 1'b1; bus_a.rvalid = 1'b1; bus_a.rdata = d; bus_a.rlast = 1'b1; bus_a.rresp = 2'b00;
    tick();
    bus_a.miss_valid = 1'b0;
    checks++; if (bus_a.arvalid !== 1'b1) begin errors++; $display("FAIL t1_arvalid got=%0h exp=1", bus_a.arvalid); end
    checks++; if (bus_a.araddr !== 64'h0000_0000_8000_0128) begin errors++; $display("FAIL t1_araddr got=%h exp=80000128", bus_a.araddr); end
    checks++; if (bus_a.arlen !== 8'd0) begin errors++; $display("FAIL t1_arlen got=%0d exp=0", bus_a.arlen); end
    checks++; if ({bus_a.arsize, bus_a.arburst, bus_a.arid} !== {3'b011, 2'b01, 4'd0}) begin errors++; $display("FAIL t1_arattr got=%0h/%0h/%0h exp=3/1/0", bus_a.arsize, bus_a.arburst, bus_a.arid); end
    checks++; if (bus_a.miss_ready !== 1'b0) begin errors++; $display("FAIL t1_miss_ready got=%0h exp=0", bus_a.miss_ready); end
    tick();
    checks++; if (bus_a.rready !== 1'b1 || bus_a.arvalid !== 1'b0) begin errors++; $display("FAIL t1_rphase got rready=%0h arvalid=%0h exp 1/0", bus_a.rready, bus_a.arvalid); end
    checks++; if (bus_a.resp_valid !== 1'b0) begin errors++; $display("FAIL t1_resp_early got=%0h exp=0", bus_a.resp_valid); end
    tick();
    checks++; if (bus_a.refresh !== 1'b1) begin errors++; $display("FAIL t1_refresh got=%0h exp=1", bus_a.refresh); end
    checks++; if (bus_a.resp_valid !== 1'b1) begin errors++; $display("FAIL t1_resp_valid got=%0h exp=1", bus_a.resp_valid); end
    checks++; if (bus_a.refill_way !== 1'b1) begin errors++; $display("FAIL t1_way got=%0h exp=1", bus_a.refill_way); end
    checks++; if (bus_a.refill_index !== 6'd37) begin errors++; $display("FAIL t1_index got=%0d exp=37", bus_a.refill_index); end
    checks++; if (bus_a.cacheline_new !== d) begin errors++; $display("FAIL t1_line got=%h exp=%h", bus_a.cacheline_new, d); end
    checks++; if (bus_a.resp_rdata !== d) begin errors++; $display("FAIL t1_rdata got=%h exp=%h", bus_a.resp_rdata, d); end
`ifdef ICACHE_REFILL_ERR_EN
    checks++; if (bus_a.resp_err !== 1'b0) begin errors++; $display("FAIL t1_resp_err got=%0h exp=0", bus_a.resp_err); end
`endif
    bus_a.rvalid = 1'b0; bus_a.rlast = 1'b0; bus_a.arready = 1'b0;
    tick();
    checks++; if (bus_a.refresh !== 1'b0 || bus_a.resp_valid !== 1'b0) begin errors++; $display("FAIL t1_one_cycle got refresh=%0h resp=%0h exp 0/0", bus_a.refresh, bus_a.resp_valid); end
    checks++; if (bus_a.miss_ready !== 1'b1) begin errors++; $display("FAIL t1_back_idle got=%0h exp=1", bus_a.miss_ready); end
  endtask

  task automatic test_uncached();
    logic [63:0] d;
    d = 64'h0123_4567_89AB_CDEF;
    bus_a.miss_valid = 1'b1; bus_a.miss_addr = 64'h0000_0000_1000_0004;
    bus_a.miss_cache = 1'b0; bus_a.miss_lru = 1'b0;
    bus_a.arready = 1'b1; bus_a.rvalid = 1'b1; bus_a.rdata = d; bus_a.rlast = 1'b1; bus_a.rresp = 2'b00;
    tick();
    bus_a.miss_valid = 1'b0;
    checks++; if (bus_a.araddr !== 64'h0000_0000_1000_0000) begin errors++; $display("FAIL t2_araddr got=%h exp=10000000", bus_a.araddr); end
    checks++; if (bus_a.arlen !== 8'd0) begin errors++; $display("FAIL t2_arlen got=%0d exp=0", bus_a.arlen); end
    tick();
    checks++; if (bus_a.refresh !== 1'b0) begin errors++; $display("FAIL t2_refresh_r got=%0h exp=0", bus_a.refresh); end
    tick();
    checks++; if (bus_a.resp_valid !== 1'b1) begin errors++; $display("FAIL t2_resp_valid got=%0h exp=1", bus_a.resp_valid); end
    checks++; if (bus_a.resp_rdata !== d) begin errors++; $display("FAIL t2_rdata got=%h exp=%h", bus_a.resp_rdata, d); end
    checks++; if (bus_a.refresh !== 1'b0) begin errors++; $display("FAIL t2_refresh got=%0h exp=0", bus_a.refresh); end
    bus_a.rvalid = 1'b0; bus_a.rlast = 1'b0; bus_a.arready = 1'b0;
    tick();
  endtask

  task automatic test_ar_stall();
    logic [63:0] d;
    d = 64'hCAFE_F00D_1234_5678;
    bus_a.miss_valid = 1'b1; bus_a.miss_addr = 64'h0000_0000_4000_0040;
    bus_a.miss_cache = 1'b1; bus_a.miss_lru = 1'b0;
    bus_a.arready = 1'b0; bus_a.rvalid = 1'b0; bus_a.rlast = 1'b0;
    tick();
    bus_a.miss_addr = 64'h0000_0000_7777_0000;
    bus_a.miss_lru = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus_a.arvalid !== 1'b1) begin errors++; $display("FAIL t3_arvalid_%0d got=%0h exp=1", i, bus_a.arvalid); end
      checks++; if (bus_a.araddr !== 64'h0000_0000_4000_0040) begin errors++; $display("FAIL t3_araddr_%0d got=%h exp=40000040", i, bus_a.araddr); end
      checks++; if (bus_a.miss_ready !== 1'b0) begin errors++; $display("FAIL t3_miss_ready_%0d got=%0h exp=0", i, bus_a.miss_ready); end
      tick();
    end
    bus_a.miss_valid = 1'b0;
    bus_a.arready = 1'b1; bus_a.rvalid = 1'b1; bus_a.rdata = d; bus_a.rlast = 1'b1;
    tick();
    tick();
    checks++; if (bus_a.resp_rdata !== d) begin errors++; $display("FAIL t3_rdata got=%h exp=%h", bus_a.resp_rdata, d); end
    checks++; if (bus_a.refill_index !== 6'd8 || bus_a.refill_way !== 1'b0) begin errors++; $display("FAIL t3_target got idx=%0d way=%0h exp 8/0", bus_a.refill_index, bus_a.refill_way); end
    bus_a.rvalid = 1'b0; bus_a.rlast = 1'b0; bus_a.arready = 1'b0;
    tick();
    tick();
    checks++; if (bus_a.arvalid !== 1'b0 || bus_a.miss_ready !== 1'b1) begin errors++; $display("FAIL t3_no_replay got arvalid=%0h ready=%0h exp 0/1", bus_a.arvalid, bus_a.miss_ready); end
  endtask

  task automatic test_line_gapped();
    logic [255:0] exp_line;
    exp_line = {64'hD, 64'hC, 64'hB, 64'hA};
    bus_b.miss_valid = 1'b1; bus_b.miss_addr = 64'h0000_0000_2000_0010;
    bus_b.miss_cache = 1'b1; bus_b.miss_lru = 1'b0;
    bus_b.arready = 1'b1; bus_b.rvalid = 1'b0; bus_b.rlast = 1'b0; bus_b.rresp = 2'b00;
    tick();
    bus_b.miss_valid = 1'b0;
    checks++; if (bus_b.araddr !== 64'h0000_0000_2000_0000) begin errors++; $display("FAIL t4_araddr got=%h exp=20000000", bus_b.araddr); end
    checks++; if (bus_b.arlen !== 8'd3) begin errors++; $display("FAIL t4_arlen got=%0d exp=3", bus_b.arlen); end
    tick();
    checks++; if (bus_b.rready !== 1'b1) begin errors++; $display("FAIL t4_rready got=%0h exp=1", bus_b.rready); end
    for (int k = 0; k < 4; k++) begin
      bus_b.rvalid = 1'b1; bus_b.rdata = 64'hA + 64'(k); bus_b.rlast = (k == 3);
      tick();
      bus_b.rvalid = 1'b0; bus_b.rlast = 1'b0;
      if (k < 3) begin
        checks++; if (bus_b.resp_valid !== 1'b0) begin errors++; $display("FAIL t4_early_done_%0d got=%0h exp=0", k, bus_b.resp_valid); end
        tick();
      end
    end
    checks++; if (bus_b.refresh !== 1'b1 || bus_b.resp_valid !== 1'b1) begin errors++; $display("FAIL t4_strobe got refresh=%0h resp=%0h exp 1/1", bus_b.refresh, bus_b.resp_valid); end
    checks++; if (bus_b.cacheline_new !== exp_line) begin errors++; $display("FAIL t4_line got=%h exp=%h", bus_b.cacheline_new, exp_line); end
    checks++; if (bus_b.resp_rdata !== 64'hC) begin errors++; $display("FAIL t4_rdata got=%h exp=c", bus_b.resp_rdata); end
    bus_b.arready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] exp_line;
    exp_line = {64'h0, 64'h0, 64'h0, 64'h55};
    bus_b.miss_valid = 1'b1; bus_b.miss_addr = 64'h0000_0000_3000_0000;
    bus_b.miss_cache = 1'b1; bus_b.miss_lru = 1'b1;
    bus_b.arready = 1'b1; bus_b.rvalid = 1'b0; bus_b.rlast = 1'b0;
    tick();
    bus_b.miss_valid = 1'b0;
    tick();
    bus_b.rvalid = 1'b1; bus_b.rdata = 64'h11;
    tick();
    bus_b.rdata = 64'h22;
    tick();
    bus_b.rvalid = 1'b0;
    checks++; if (bus_b.rready !== 1'b1) begin errors++; $display("FAIL t5_in_burst got=%0h exp=1", bus_b.rready); end
    rst = 1'b1;
    #1;
    checks++; if (bus_b.rready !== 1'b0 || bus_b.arvalid !== 1'b0) begin errors++; $display("FAIL t5_drop got rready=%0h arvalid=%0h exp 0/0", bus_b.rready, bus_b.arvalid); end
    checks++; if (bus_b.refresh !== 1'b0 || bus_b.miss_ready !== 1'b1) begin errors++; $display("FAIL t5_idle got refresh=%0h ready=%0h exp 0/1", bus_b.refresh, bus_b.miss_ready); end
    tick();
    rst = 1'b0;
    tick();
    bus_b.miss_valid = 1'b1; bus_b.miss_addr = 64'h0000_0000_3000_0108; bus_b.miss_lru = 1'b0;
    tick();
    bus_b.miss_valid = 1'b0;
    checks++; if (bus_b.araddr !== 64'h0000_0000_3000_0100 || bus_b.arlen !== 8'd3) begin errors++; $display("FAIL t5_ar got addr=%h len=%0d exp 30000100/3", bus_b.araddr, bus_b.arlen); end
    tick();
    bus_b.rvalid = 1'b1; bus_b.rdata = 64'h55; bus_b.rlast = 1'b1;
    tick();
    bus_b.rvalid = 1'b0; bus_b.rlast = 1'b0;
    checks++; if (bus_b.refresh !== 1'b1 || bus_b.refill_index !== 6'd32) begin errors++; $display("FAIL t5_refill got refresh=%0h idx=%0d exp 1/32", bus_b.refresh, bus_b.refill_index); end
    checks++; if (bus_b.cacheline_new !== exp_line) begin errors++; $display("FAIL t5_line got=%h exp=%h", bus_b.cacheline_new, exp_line); end
    checks++; if (bus_b.resp_rdata !== 64'h0) begin errors++; $display("FAIL t5_rdata got=%h exp=0", bus_b.resp_rdata); end
    bus_b.arready = 1'b0;
    tick();
  endtask

`ifdef ICACHE_REFILL_ERR_EN
  task automatic test_bus_error();
    bus_a.miss_valid = 1'b1; bus_a.miss_addr = 64'h0000_0000_8000_0200;
    bus_a.miss_cache = 1'b1; bus_a.miss_lru = 1'b0;
    bus_a.arready = 1'b1; bus_a.rvalid = 1'b1; bus_a.rdata = 64'h99; bus_a.rlast = 1'b1; bus_a.rresp = 2'b10;
    tick();
    bus_a.miss_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus_a.resp_valid !== 1'b1) begin errors++; $display("FAIL t6_resp_valid got=%0h exp=1", bus_a.resp_valid); end
    checks++; if (bus_a.resp_err !== 1'b1) begin errors++; $display("FAIL t6_resp_err got=%0h exp=1", bus_a.resp_err); end
    checks++; if (bus_a.refresh !== 1'b0) begin errors++; $display("FAIL t6_refresh got=%0h exp=0", bus_a.refresh); end
    bus_a.rvalid = 1'b0; bus_a.rlast = 1'b0; bus_a.arready = 1'b0; bus_a.rresp = 2'b00;
    tick();
    checks++; if (bus_a.resp_err !== 1'b0) begin errors++; $display("FAIL t6_err_clear got=%0h exp=0", bus_a.resp_err); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_a.miss_valid = 1'b0; bus_a.miss_addr = 64'd0; bus_a.miss_cache = 1'b0; bus_a.miss_lru = 1'b0;
    bus_a.arready = 1'b0; bus_a.rvalid = 1'b0; bus_a.rdata = 64'd0; bus_a.rresp = 2'b00; bus_a.rlast = 1'b0;
    bus_b.miss_valid = 1'b0; bus_b.miss_addr = 64'd0; bus_b.miss_cache = 1'b0; bus_b.miss_lru = 1'b0;
    bus_b.arready = 1'b0; bus_b.rvalid = 1'b0; bus_b.rdata = 64'd0; bus_b.rresp = 2'b00; bus_b.rlast = 1'b0;
    test_reset();
    test_cached_single();
    test_uncached();
    test_ar_stall();
    test_line_gapped();
    test_reset_mid_burst();
`ifdef ICACHE_REFILL_ERR_EN
    test_bus_error();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
